// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: instruction formats, base opcodes
// and the canonical NOP, common to the encoder and the decoder.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32i_enc_pack.sv
// Combinational RV32I field packer with optional immediate range
// check (enabled by RV32I_ENC_CHECK_EN).
module rv32i_enc_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        bad
);

  fmt_e f;
  logic illegal;
  logic range_bad;

  assign f = fmt_e'(fmt);

  // Scatter the fields into the word; illegal formats become a NOP
  always_comb begin
    instr   = NOP;
    illegal = 1'b0;
    case (f)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3,
                      imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                      imm[4:1], imm[11], opcode};
      FMT_U: instr = {imm[31:12], rd, opcode};
      FMT_J: instr = {imm[20], imm[10:1], imm[11],
                      imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
  end

`ifdef RV32I_ENC_CHECK_EN
  // Flag immediates that do not fit the format's field
  always_comb begin
    range_bad = 1'b0;
    case (f)
      FMT_I, FMT_S:
        range_bad = imm != {{20{imm[11]}}, imm[11:0]};
      FMT_B:
        range_bad = (imm != {{19{imm[12]}}, imm[12:0]})
                  | imm[0];
      FMT_J:
        range_bad = (imm != {{11{imm[20]}}, imm[20:0]})
                  | imm[0];
      FMT_U:
        range_bad = imm[11:0] != 12'd0;
      default:
        range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign bad = illegal | range_bad;

endmodule

// File: rtl/rv32i_enc.sv
// RV32I instruction encoder: field bundle in, packed word out through
// a 2-entry FIFO. RV32I_ENC_CHECK_EN adds immediate range checking.
module rv32i_enc
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             err,
  input  logic             clr_err
);

  logic [31:0] enc_word;
  logic        enc_bad;

  logic [31:0] mem [2];
  logic        wptr;
  logic        rptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  rv32i_enc_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .instr  (enc_word),
    .bad    (enc_bad)
  );

  // in_ready comes from the registered count only
  assign in_ready  = ~count[1];
  assign out_valid = count != 2'd0;
  assign out_instr = mem[rptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= enc_word;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Count words handed to the consumer, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instr_cnt <= '0;
    else if (pop) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  // Sticky error; a new offending accept beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (push & enc_bad) err <= 1'b1;
    else if (clr_err) err <= 1'b0;
  end

endmodule

// File: tb/tb_rv32i_enc.sv
// Self-checking bench for rv32i_enc: directed cases plus random
// traffic against a queue-based reference model.
module tb_rv32i_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] instr_cnt;
  logic        err;
  logic        clr_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic [15:0] m_cnt;
  logic        m_err;

  always #5 clk = ~clk;

  rv32i_enc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .instr_cnt (instr_cnt),
    .err       (err),
    .clr_err   (clr_err)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder: arithmetic placement of each field
  task automatic ref_enc(output logic [31:0] w, output logic b);
    logic [31:0] imm, op, f3, f7, rd, r1, r2, base;
    int s;
    imm  = in_imm;
    op   = 32'(in_opcode);
    f3   = 32'(in_funct3);
    f7   = 32'(in_funct7);
    rd   = 32'(in_rd);
    r1   = 32'(in_rs1);
    r2   = 32'(in_rs2);
    s    = $signed(imm);
    base = (r1 << 15) + (f3 << 12) + op;
    b    = 1'b0;
    case (in_fmt)
      3'd0: w = (f7 << 25) + (r2 << 20) + base + (rd << 7);
      3'd1: begin
        w = ((imm & 32'hfff) << 20) + base + (rd << 7);
        b = s < -2048 || s > 2047;
      end
      3'd2: begin
        w = (((imm >> 5) & 32'h7f) << 25) + (r2 << 20) + base
          + ((imm & 32'h1f) << 7);
        b = s < -2048 || s > 2047;
      end
      3'd3: begin
        w = (((imm >> 12) & 1) << 31) + (((imm >> 5) & 32'h3f) << 25)
          + (r2 << 20) + base + (((imm >> 1) & 32'hf) << 8)
          + (((imm >> 11) & 1) << 7);
        b = s < -4096 || s > 4095 || (imm % 2) != 0;
      end
      3'd4: begin
        w = (imm & 32'hffff_f000) + (rd << 7) + op;
        b = (imm % 4096) != 0;
      end
      3'd5: begin
        w = (((imm >> 20) & 1) << 31) + (((imm >> 1) & 32'h3ff) << 21)
          + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 32'hff) << 12)
          + (rd << 7) + op;
        b = s < -1048576 || s > 1048575 || (imm % 2) != 0;
      end
      default: begin
        w = 32'h0000_0013;
        b = 1'b1;
      end
    endcase
`ifndef RV32I_ENC_CHECK_EN
    if (in_fmt < 3'd6) b = 1'b0;
`endif
  endtask

  task automatic drive(logic v, logic [2:0] fmt, logic [6:0] op,
                       logic [2:0] f3, logic [6:0] f7, logic [4:0] rd,
                       logic [4:0] r1, logic [4:0] r2,
                       logic [31:0] imm);
    in_valid  = v;
    in_fmt    = fmt;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = r1;
    in_rs2    = r2;
    in_imm    = imm;
  endtask

  // One clock cycle: check visible state, advance model, check after
  task automatic step();
    logic [31:0] w;
    logic b, push, pop;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("out_instr", out_instr, q[0]);
    ref_enc(w, b);
    push = in_valid && q.size() < 2;
    pop  = out_ready && q.size() != 0;
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      m_cnt++;
    end
    if (push) q.push_back(w);
    if (push && b) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
    @(negedge clk);
    chk("err", 32'(err), 32'(m_err));
    chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = '0;
    m_err = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    drive(1'b0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    rst = 1'b0;

    // ADD x3,x1,x2
    drive(1, 3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    drive(0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("add_word", out_instr, 32'h0020_81B3);
    step();
    chk("add_cnt", 32'(instr_cnt), 32'd1);

    // ADDI x5,x0,-1
    drive(1, 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
          32'hFFFF_FFFF);
    step();
    drive(0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("addi_word", out_instr, 32'hFFF0_0293);
    chk("addi_err", 32'(err), 32'd0);
    step();

    // BEQ x1,x2,+8 then misaligned +7
    drive(1, 3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    step();
    drive(0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("beq_word", out_instr, 32'h0020_8463);
    step();
    drive(1, 3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
    step();
    drive(0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
`ifdef RV32I_ENC_CHECK_EN
    chk("beq7_err", 32'(err), 32'd1);
`else
    chk("beq7_err", 32'(err), 32'd0);
`endif
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Backpressure: three offers, only two fit
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd4, 7'b0110111, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0,
            32'(i + 1) << 12);
      step();
    end
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    drive(0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    out_ready = 1'b1;
    chk("bp_head", out_instr, 32'h0000_10B7);
    repeat (3) step();
    chk("bp_drained", 32'(in_ready), 32'd1);

    // Illegal format, clear, then clear racing a new illegal accept
    drive(1, 3'd7, 7'h7f, 3'd7, 7'h7f, 5'd9, 5'd9, 5'd9, 32'd1);
    step();
    drive(0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("ill_word", out_instr, 32'h0000_0013);
    chk("ill_err", 32'(err), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_err", 32'(err), 32'd0);
    drive(1, 3'd6, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    drive(0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("set_wins", 32'(err), 32'd1);
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] imm;
      case ($urandom % 4)
        0: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
        1: imm = $urandom;
        2: imm = 32'($signed($urandom_range(0, 4095)) - 2048) << 1;
        default: imm = $urandom & 32'hffff_f000;
      endcase
      drive(($urandom % 4) != 0, 3'($urandom % 8), 7'($urandom),
            3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), imm);
      out_ready = ($urandom % 3) != 0;
      clr_err   = ($urandom % 8) == 0;
      step();
    end
    clr_err = 1'b0;

    // Asynchronous reset with a full buffer
    out_ready = 1'b0;
    drive(1, 3'd0, 7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    repeat (3) step();
    chk("full_before_rst", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_cnt", 32'(instr_cnt), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    out_ready = 1'b1;
    chk("post_rst_instr", out_instr, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_enc.md
# rv32i_enc

Pipelined RV32I instruction encoder: the inverse of the RV32I decoder. It accepts a decoded instruction (format, opcode, funct fields, register indices, full 32-bit immediate) over a valid/ready handshake. It packs the fields into the 32-bit RISC-V word and presents the words in order through a 2-entry output buffer with valid/ready. It sits between the test/program generator and instruction memory, so programs can be built from fields and cross-checked against the decoder.

## Interface
Parameters:
- CNT_W, 16, width of the emitted-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- in_opcode  in  7  opcode field
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate as a byte offset/value (not pre-shifted)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction
- instr_cnt  out  CNT_W  words emitted (out_valid & out_ready), wraps
- err  out  1  sticky error flag
- clr_err  in  1  synchronous clear of err

## Operation
- Packing per format:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Illegal fmt (6, 7): emit the NOP 32'h0000_0013 and set err.
- Unused fields for a format are ignored.
- Output buffer: 2-entry FIFO with write pointer, read pointer and 2-bit count (0..2).
  - in_ready = (count < 2).
  - Push on in_valid & in_ready; pop on out_valid & out_ready.
  - out_valid = (count != 0); out_instr = head entry.
- Simultaneous push and pop:
  - count unchanged; pointers both advance (1-bit wrap).
  - When count == 1, the popped head is the old word and the new word becomes the head next cycle.
- instr_cnt increments on each pop and wraps from 2^CNT_W−1 to 0.
- err:
  - Set on any accepted bundle that is erroneous.
  - Cleared by clr_err. If set and clear happen in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-transfer) clears:
  - FIFO contents, count and pointers
  - err and instr_cnt
  - out_valid=0, out_instr=0, in_ready=1 on the first cycle after release

## Timing
- Encoding is combinational into the FIFO write port, so latency is 1 cycle from accept to out_valid.
- Throughput is 1 word/cycle while out_ready stays high.
- in_ready depends only on registered count. No combinational path exists from out_ready to in_ready.
- out_instr stays stable while out_valid & !out_ready.
- err is registered and rises 1 cycle after the offending accept.

## Configuration
- RV32I_ENC_CHECK_EN defined: each accepted bundle is also range-checked, and a failure sets err. The word is still emitted with the immediate truncated. Checks per format:
  - I and S: in_imm equals the sign-extension of in_imm[11:0].
  - B: 13-bit signed range and in_imm[0]==0.
  - J: 21-bit signed range and in_imm[0]==0.
  - U: in_imm[11:0]==0.
- Undefined: no range checks. Immediates are truncated silently, and err is set only by illegal fmt.

## Structure
- Package rv32i_pkg holds:
  - the fmt_e enum (FMT_R..FMT_J)
  - opcode constants (OP_OP=7'b0110011, OP_IMM=7'b0010011, OP_BRANCH=7'b1100011, OP_STORE, OP_LUI, OP_JAL)
  - the NOP constant
- These are shared with the decoder.
- One sub-module, rv32i_enc_pack: purely combinational field packing plus range check, instantiated once ahead of the FIFO.

## Test plan
- ADD x3,x1,x2 (R, op 0110011, f3 0, f7 0) -> out_instr 32'h0020_81B3 one cycle after accept; instr_cnt=1.
- ADDI x5,x0,-1 (I, imm 32'hFFFF_FFFF) -> 32'hFFF0_0293, err=0.
- BEQ x1,x2,+8 (B, imm 8) -> 32'h0020_8463. With imm 7 and CHECK_EN defined, err=1; without it, err stays 0.
- Hold out_ready=0, push 3 bundles -> in_ready drops after 2 pushes. Release out_ready -> words pop in order, then in_ready=1.
- fmt=7 -> out_instr 32'h0000_0013 and err=1. clr_err pulse -> err=0. clr_err asserted with a new illegal accept -> err stays 1.
- Assert rst with count=2 -> out_valid=0 and in_ready=1 immediately, instr_cnt=0.
